audio_pkt_fifo_wr_ctrl: RTL and testbench
=========================================

// Module: audio_pkt_fifo_wr_ctrl
// PURPOSE
//  Write-side controller of the audio-data packet async FIFO. Accepts audio samples in the
//  wr_clk domain, drives the write port of the distributed SDP RAM (addr/en/data), keeps the
//  binary and Gray write pointers, and synchronises the read-side Gray pointer.
//  Produces full/almost_full/water level, an overflow pulse, and a pkt_ready pulse for each
//  PKT_LEN accepted samples, which feeds the UDP packetiser.
// PARAMETERS
//  ADDR_WIDTH  10    RAM address width, range 4-10; FIFO depth = 2**ADDR_WIDTH
//  DATA_WIDTH  16    sample width, range 1-256
//  AFULL_NUM   1000  almost_full asserts when level >= AFULL_NUM (1..2**ADDR_WIDTH-1)
//  PKT_LEN     256   samples per packet, range 1..2**ADDR_WIDTH
// PORTS
//  wr_clk          in   1             write-domain clock
//  asyn_rst        in   1             reset, asynchronous, active-high
//  wr_en_i         in   1             push request
//  wr_data_i       in   DATA_WIDTH    sample to push
//  rd_ptr_gray_i   in   ADDR_WIDTH+1  read pointer, Gray coded, rd_clk domain
//  ram_wr_en       out  1             RAM write enable
//  ram_wr_addr     out  ADDR_WIDTH    RAM write address
//  ram_wr_data     out  DATA_WIDTH    RAM write data
//  wr_ptr_gray_o   out  ADDR_WIDTH+1  registered Gray write pointer, to read side
//  full            out  1             FIFO full, registered
//  almost_full     out  1             level >= AFULL_NUM, registered
//  wr_water_level  out  ADDR_WIDTH+1  occupied words as seen from write side, registered
//  overflow        out  1             one-cycle pulse: push attempted while full
//  pkt_ready       out  1             one-cycle pulse: PKT_LEN further samples accepted
// BEHAVIOUR
//  - Reset: wr_ptr, wr_ptr_gray_o, sync flops, level, pkt counter = 0; full, almost_full,
//    overflow, pkt_ready = 0. Reset mid-stream discards all state; the read side is reset too.
//  - accept = wr_en_i & ~full. ram_wr_en = accept (combinational), ram_wr_addr =
//    wr_ptr[ADDR_WIDTH-1:0], ram_wr_data = wr_data_i; RAM captures on the same wr_clk edge.
//  - wr_ptr (ADDR_WIDTH+1 bits binary) += accept, wraps modulo 2**(ADDR_WIDTH+1).
//    wr_ptr_gray_o <= bin2gray(wr_ptr_next): changes together with wr_ptr, one bit per step.
//  - rd_ptr_gray_i passes through a 2-flop synchroniser, then gray2bin -> rd_ptr_bin.
//    Read-side progress is visible at the earliest 2 wr_clk after the rd_ptr_gray_i change.
//  - full <= (bin2gray(wr_ptr_next) == {~rd_sync[MSB:MSB-1], rd_sync[MSB-2:0]}).
//    full asserts in the same edge as the write that fills the last slot, so a push in the
//    following cycle is already blocked. full deasserts >=2 cycles after the reader pops.
//  - wr_water_level <= wr_ptr_next - rd_ptr_bin, modulo 2**(ADDR_WIDTH+1); this value never
//    exceeds 2**ADDR_WIDTH. almost_full <= (wr_water_level_next >= AFULL_NUM).
//  - overflow <= wr_en_i & full. The write is dropped and the pointer does not move.
//  - pkt counter counts accepted samples, 0..PKT_LEN-1. On an accept with cnt==PKT_LEN-1:
//    cnt <= 0 and pkt_ready <= 1 for exactly one cycle, in the cycle after the last write.
//    pkt_ready does not depend on full.
//  - Simultaneous push and synchronised read advance in one cycle: level = old+1-pops,
//    computed from the next pointers, with no double counting.
//  - Levels are pessimistic: reported full/level are >= the true value, never lower.
// STRUCTURE
//  - Package audio_fifo_pkg: functions bin2gray and gray2bin, parameterised by width.
//  - Sub-module audio_ptr_sync: 2-flop Gray synchroniser + gray2bin, with ports clk,
//    asyn_rst, gray_i, bin_o. It is instantiated once here; the read controller reuses it.
//  - Top: pointer/flag logic and the packet counter. No RAM inside this block.
// TESTING
//  1 Reset: assert asyn_rst mid-push -> all outputs 0 immediately; ram_wr_en=0 while rst.
//  2 Fill: ADDR_WIDTH=4, rd ptr held 0, push 16 -> full=1 on the edge of the 16th write;
//    17th push -> ram_wr_en=0, overflow pulse, wr_ptr stays 16, level=16.
//  3 Drain: after case 2, rd_ptr_gray_i=bin2gray(4) -> full=0 and level=12 exactly 3 cycles
//    later. The next 4 pushes are accepted, then full=1 again.
//  4 Wrap: stream 100 words with the reader keeping up -> ram_wr_addr wraps 15->0,
//    wr_ptr_gray_o changes one bit per step, and no false full occurs.
//  5 Packet: PKT_LEN=8, push 20 words with gaps -> pkt_ready pulses after word 8 and after
//    word 16 only, each 1 cycle wide.
//  6 almost_full: AFULL_NUM=12, ADDR_WIDTH=4 -> asserts with level 12, deasserts at 11.

Source files
------------

// File: rtl/audio_fifo_pkg.sv
// Shared Gray/binary pointer helpers for the audio packet async FIFO.
// Latency: pure functions, no state.
// Backpressure: not applicable.
package audio_fifo_pkg;

    // Widest pointer any FIFO instance uses. Narrower pointers are zero-extended on the way in
    // and truncated on the way out; zero upper bits leave both conversions unchanged.
    localparam int PTR_MAX_W = 16;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/audio_ptr_sync.sv
// Brings a Gray-coded pointer from the far clock domain in and converts it to binary.
// Latency: 2 clk edges from gray_i change to bin_o change (bin_o is combinational off flop 2).
// Backpressure: none; samples every cycle.
module audio_ptr_sync
    import audio_fifo_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         asyn_rst,
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    // Two-stage shift; Gray coding guarantees at most one bit is in flight per step.
    always_comb begin
        meta_d = gray_i;
        sync_d = meta_q;
    end

    // Synchroniser flops, cleared by the shared asynchronous reset.
    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign bin_o = W'(gray2bin(ptr_t'(sync_q)));

endmodule

// File: rtl/audio_pkt_fifo_wr_ctrl.sv
// Write-side controller of the audio packet async FIFO: RAM write port, pointers, flags, packet pulse.
// Latency: RAM write same edge as accept; flags/level/pulses registered one edge after the write.
// Backpressure: pushes while full are dropped and flagged with a one-cycle overflow pulse.
module audio_pkt_fifo_wr_ctrl
    import audio_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int AFULL_NUM  = 1000,
    parameter int PKT_LEN    = 256
) (
    input  logic                  wr_clk,
    input  logic                  asyn_rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_i,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_water_level,
    output logic                  overflow,
    output logic                  pkt_ready
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] wr_gray_q, wr_gray_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] rd_ptr_bin;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          pkt_rdy_q, pkt_rdy_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          accept;

    audio_ptr_sync #(
        .W(PW)
    ) u_rd_sync (
        .clk     (wr_clk),
        .asyn_rst(asyn_rst),
        .gray_i  (rd_ptr_gray_i),
        .bin_o   (rd_ptr_bin)
    );

    // The RAM must never see a write while reset is held, even if a push is requested.
    assign accept = wr_en_i & ~full_q & ~asyn_rst;

    // Next pointer, flags and packet counter, all derived from the post-write pointer so a
    // simultaneous push and synchronised pop are counted exactly once each.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(accept);
        wr_gray_d = PW'(bin2gray(ptr_t'(wr_ptr_d)));
        level_d   = wr_ptr_d - rd_ptr_bin;
        // Level of exactly DEPTH is the same condition as the Gray compare with the two
        // top bits of the read pointer inverted.
        full_d    = (level_d == DEPTH);
        afull_d   = (level_d >= PW'(AFULL_NUM));
        ovf_d     = wr_en_i & full_q;
        pkt_cnt_d = pkt_cnt_q;
        pkt_rdy_d = 1'b0;
        if (accept) begin
            if (pkt_cnt_q == CW'(PKT_LEN - 1)) begin
                pkt_cnt_d = '0;
                pkt_rdy_d = 1'b1;
            end else begin
                pkt_cnt_d = pkt_cnt_q + CW'(1);
            end
        end
    end

    // State registers; reset discards everything, the read side is reset alongside.
    always_ff @(posedge wr_clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            wr_ptr_q  <= '0;
            wr_gray_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            pkt_rdy_q <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            wr_gray_q <= wr_gray_d;
            level_q   <= level_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
            pkt_rdy_q <= pkt_rdy_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign ram_wr_en      = accept;
    assign ram_wr_addr    = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_wr_data    = wr_data_i;
    assign wr_ptr_gray_o  = wr_gray_q;
    assign full           = full_q;
    assign almost_full    = afull_q;
    assign wr_water_level = level_q;
    assign overflow       = ovf_q;
    assign pkt_ready      = pkt_rdy_q;

endmodule

// File: tb/tb_audio_pkt_fifo_wr_ctrl.sv
// Self-checking bench for the audio FIFO write controller (depth 16, afull 12, packet 8).
// Latency: checks combinational RAM port before each edge, registered outputs 1 ns after.
// Backpressure: reader model only pops words that were actually written.
module tb_audio_pkt_fifo_wr_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          wr_clk = 1'b0;
    logic          asyn_rst;
    logic          wr_en_i;
    logic [DW-1:0] wr_data_i;
    logic [AW:0]   rd_ptr_gray_i;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW:0]   wr_ptr_gray_o;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wr_water_level;
    logic          overflow;
    logic          pkt_ready;

    audio_pkt_fifo_wr_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .AFULL_NUM (12),
        .PKT_LEN   (8)
    ) dut (
        .wr_clk        (wr_clk),
        .asyn_rst      (asyn_rst),
        .wr_en_i       (wr_en_i),
        .wr_data_i     (wr_data_i),
        .rd_ptr_gray_i (rd_ptr_gray_i),
        .ram_wr_en     (ram_wr_en),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data),
        .wr_ptr_gray_o (wr_ptr_gray_o),
        .full          (full),
        .almost_full   (almost_full),
        .wr_water_level(wr_water_level),
        .overflow      (overflow),
        .pkt_ready     (pkt_ready)
    );

    always #5 wr_clk = ~wr_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain counts of words written and popped since reset.
    int wr_cnt, rd_cnt, rd_d1, rd_d2, level_m, pkt_seen, wraps;
    bit full_m, afull_m, ovf_m, pkt_m, last_wen;

    typedef struct {
        bit we;
        int rd;
        bit e_wen;
        int e_lvl;
        bit e_full;
        bit e_afull;
        bit e_ovf;
        bit e_pkt;
    } vec_t;

    vec_t tbl[27];

    function automatic logic [AW:0] to_gray(input int x);
        logic [AW:0] b;
        b = x[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        wr_cnt  = 0;
        rd_cnt  = 0;
        rd_d1   = 0;
        rd_d2   = 0;
        level_m = 0;
        full_m  = 0;
        afull_m = 0;
        ovf_m   = 0;
        pkt_m   = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, " gray"},  wr_ptr_gray_o, to_gray(wr_cnt));
        chk({tag, " full"},  full, full_m);
        chk({tag, " afull"}, almost_full, afull_m);
        chk({tag, " level"}, wr_water_level, level_m);
        chk({tag, " ovf"},   overflow, ovf_m);
        chk({tag, " pkt"},   pkt_ready, pkt_m);
    endtask

    // One clock cycle: drive inputs, check RAM port, advance model, check registered outputs.
    task automatic step(input bit we, input int rd_new);
        bit acc;
        @(negedge wr_clk);
        wr_en_i       = we;
        wr_data_i     = DW'($urandom);
        rd_cnt        = rd_new;
        rd_ptr_gray_i = to_gray(rd_new);
        #1;
        acc      = we && !full_m;
        last_wen = ram_wr_en;
        chk("ram_wr_en", ram_wr_en, acc);
        chk("ram_wr_addr", ram_wr_addr, wr_cnt % 16);
        if (we) chk("ram_wr_data", ram_wr_data, wr_data_i);
        if (acc && (wr_cnt % 16 == 15)) wraps++;
        @(posedge wr_clk);
        ovf_m   = we && full_m;
        wr_cnt  = wr_cnt + int'(acc);
        level_m = wr_cnt - rd_d2;
        rd_d2   = rd_d1;
        rd_d1   = rd_new;
        full_m  = (level_m == 16);
        afull_m = (level_m >= 12);
        pkt_m   = acc && (wr_cnt % 8 == 0);
        if (pkt_m) pkt_seen++;
        #1;
        chk_regs("step");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " ram_wr_en"}, ram_wr_en, 0);
        chk({tag, " addr"},      ram_wr_addr, 0);
        chk({tag, " gray"},      wr_ptr_gray_o, 0);
        chk({tag, " full"},      full, 0);
        chk({tag, " afull"},     almost_full, 0);
        chk({tag, " level"},     wr_water_level, 0);
        chk({tag, " ovf"},       overflow, 0);
        chk({tag, " pkt"},       pkt_ready, 0);
    endtask

    // Asynchronous reset asserted mid-cycle with a push pending.
    task automatic mid_reset();
        @(posedge wr_clk);
        #2;
        wr_en_i  = 1'b1;
        asyn_rst = 1'b1;
        #1;
        check_all_zero("rst");
        rd_ptr_gray_i = '0;
        model_clear();
        repeat (2) @(negedge wr_clk);
        chk("rst hold ram_wr_en", ram_wr_en, 0);
        wr_en_i  = 1'b0;
        asyn_rst = 1'b0;
    endtask

    initial begin
        int rd;
        asyn_rst      = 1'b1;
        wr_en_i       = 1'b1;
        wr_data_i     = '0;
        rd_ptr_gray_i = '0;
        pkt_seen      = 0;
        wraps         = 0;
        last_wen      = 0;
        model_clear();
        #1;
        check_all_zero("init");
        repeat (2) @(negedge wr_clk);
        wr_en_i  = 1'b0;
        asyn_rst = 1'b0;

        // Fill, overflow, drain by 4, refill, then drain below almost_full.
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{1, 0, 1, i + 1, (i == 15), (i >= 11), 0, (i == 7 || i == 15)};
        end
        tbl[16] = '{1, 0, 0, 16, 1, 1, 1, 0};
        tbl[17] = '{0, 4, 0, 16, 1, 1, 0, 0};
        tbl[18] = '{0, 4, 0, 16, 1, 1, 0, 0};
        tbl[19] = '{0, 4, 0, 12, 0, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            tbl[20 + i] = '{1, 4, 1, 13 + i, (i == 3), 1, 0, 0};
        end
        tbl[24] = '{0, 9, 0, 16, 1, 1, 0, 0};
        tbl[25] = '{0, 9, 0, 16, 1, 1, 0, 0};
        tbl[26] = '{0, 9, 0, 11, 0, 0, 0, 0};

        for (int i = 0; i < 27; i++) begin
            step(tbl[i].we, tbl[i].rd);
            chk("tbl wen",   last_wen, tbl[i].e_wen);
            chk("tbl level", wr_water_level, tbl[i].e_lvl);
            chk("tbl full",  full, tbl[i].e_full);
            chk("tbl afull", almost_full, tbl[i].e_afull);
            chk("tbl ovf",   overflow, tbl[i].e_ovf);
            chk("tbl pkt",   pkt_ready, tbl[i].e_pkt);
        end
        chk("tbl wr_ptr stays 20", wr_ptr_gray_o, to_gray(20));

        // Reset in the middle of a push stream.
        step(1, rd_cnt);
        mid_reset();

        // Streaming with the reader keeping up: address wraps, no false full.
        wraps = 0;
        for (int i = 0; i < 100; i++) begin
            rd = (rd_cnt < wr_cnt) ? rd_cnt + 1 : rd_cnt;
            step(1, rd);
            chk("stream no full", full, 0);
        end
        chk("stream wraps", wraps, 6);

        // Packet pulses with gaps: 20 words -> exactly two pulses.
        mid_reset();
        pkt_seen = 0;
        for (int i = 0; i < 60 && wr_cnt < 20; i++) begin
            rd = (rd_cnt < wr_cnt) ? rd_cnt + 1 : rd_cnt;
            step((i % 3) != 0, rd);
        end
        repeat (4) step(0, rd_cnt);
        chk("pkt words", wr_cnt, 20);
        chk("pkt pulses", pkt_seen, 2);

        // Random pushes and pops against the model.
        for (int i = 0; i < 400; i++) begin
            rd = (rd_cnt < wr_cnt && $urandom_range(1, 0) == 1) ? rd_cnt + 1 : rd_cnt;
            step($urandom_range(3, 0) != 0, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
